// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback controller: source encoding,
// queue entry layout and the destination-match helper used by the hazard check.
package wb_pkg;

    localparam int unsigned REG_ADDR_WIDTH = 5;
    localparam int unsigned DATA_WIDTH     = 32;
    localparam int unsigned SEL_WIDTH      = 2;

    typedef enum logic [1:0] {
        WB_DMEM = 2'b00,
        WB_ALU  = 2'b01,
        WB_PC4  = 2'b10,
        WB_NONE = 2'b11
    } wb_src_t;

    typedef struct packed {
        logic [REG_ADDR_WIDTH-1:0] rd;
        wb_src_t                   src;
        logic [DATA_WIDTH-1:0]     data;
    } wb_entry_t;

    // x0 is hardwired to zero, so it can never be a true dependency.
    function automatic logic rd_hits(input logic [REG_ADDR_WIDTH-1:0] rd,
                                     input logic [REG_ADDR_WIDTH-1:0] rs1,
                                     input logic [REG_ADDR_WIDTH-1:0] rs2);
        return (rd != '0) && ((rd == rs1) || (rd == rs2));
    endfunction

endpackage

// File: rtl/wb_queue.sv
// Generic circular FIFO with wrap-bit pointers, occupancy count and a flat
// view of every slot plus its valid bit for associative lookups.
module wb_queue #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [WIDTH-1:0]       wdata_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [AW:0]            count_o,
    output logic [DEPTH*WIDTH-1:0] entries_o,
    output logic [DEPTH-1:0]       valid_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic [AW-1:0]    offset;
    logic             push_en, pop_en;

    always_comb begin
        empty_o = (wptr_q == rptr_q);
        full_o  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
        count_o = wptr_q - rptr_q;
        rdata_o = mem_q[rptr_q[AW-1:0]];
        push_en = push_i && !full_o;
        pop_en  = pop_i && !empty_o;
    end

    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push_en) begin
            mem_d[wptr_q[AW-1:0]] = wdata_i;
            wptr_d = wptr_q + 1'b1;
        end
        if (pop_en) begin
            rptr_d = rptr_q + 1'b1;
        end
    end

    // A slot is live when its distance from the read index is below the count.
    always_comb begin
        entries_o = '0;
        valid_o   = '0;
        offset    = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            entries_o[i*WIDTH +: WIDTH] = mem_q[i];
            offset     = AW'(i) - rptr_q[AW-1:0];
            valid_o[i] = ({1'b0, offset} < count_o);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

endmodule

// File: rtl/wb_ctrl.sv
// In-order writeback controller: queues retiring instructions, drives the
// register-file write port and mux select, flags pending-destination hazards.
module wb_ctrl #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned SEL_WIDTH      = 2,
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned DEPTH          = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      iss_valid,
    output logic                      iss_ready,
    input  logic [REG_ADDR_WIDTH-1:0] iss_rd,
    input  logic [SEL_WIDTH-1:0]      iss_src,
    input  logic [DATA_WIDTH-1:0]     iss_data,
    input  logic                      ld_rvalid,
    output logic [SEL_WIDTH-1:0]      wb_sel,
    output logic [DATA_WIDTH-1:0]     wb_alu,
    output logic [DATA_WIDTH-1:0]     wb_pc4,
    output logic                      rf_we,
    output logic [REG_ADDR_WIDTH-1:0] rf_waddr,
    input  logic [REG_ADDR_WIDTH-1:0] hz_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] hz_rs2,
    output logic                      hazard,
    output logic                      err,
    output logic                      busy
);

    import wb_pkg::*;

    localparam int unsigned EW = $bits(wb_entry_t);
    localparam int unsigned AW = $clog2(DEPTH);

    wb_entry_t            entry_in, head, slot;
    logic [EW-1:0]        q_rdata;
    logic [DEPTH*EW-1:0]  q_entries;
    logic [DEPTH-1:0]     q_valid;
    logic [AW:0]          q_count;
    logic                 q_full, q_empty;
    logic                 push, retire, stray;
    logic                 err_q, err_d;

    always_comb begin
        entry_in = '{rd: iss_rd, src: wb_src_t'(iss_src), data: iss_data};
        push     = iss_valid && !q_full;
    end

    wb_queue #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_i    (push),
        .pop_i     (retire),
        .wdata_i   (entry_in),
        .rdata_o   (q_rdata),
        .full_o    (q_full),
        .empty_o   (q_empty),
        .count_o   (q_count),
        .entries_o (q_entries),
        .valid_o   (q_valid)
    );

    // Loads block the head until data memory answers; everything else drains at once.
    always_comb begin
        head      = wb_entry_t'(q_rdata);
        wb_sel    = SEL_WIDTH'(WB_ALU);
        rf_waddr  = '0;
        wb_alu    = '0;
        wb_pc4    = '0;
        retire    = 1'b0;
        rf_we     = 1'b0;
        if (!q_empty) begin
            wb_sel   = SEL_WIDTH'(head.src);
            rf_waddr = head.rd;
            wb_alu   = head.data;
            wb_pc4   = head.data;
            retire   = (head.src != WB_DMEM) || ld_rvalid;
            rf_we    = retire && (head.src != WB_NONE) && (head.rd != '0);
        end
        iss_ready = !q_full;
        busy      = (q_count != '0);
    end

    // Conservative: the head still counts even in the cycle it retires.
    always_comb begin
        hazard = 1'b0;
        slot   = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            slot = wb_entry_t'(q_entries[i*EW +: EW]);
            if (q_valid[i] && rd_hits(slot.rd, hz_rs1, hz_rs2)) begin
                hazard = 1'b1;
            end
        end
    end

    always_comb begin
        stray = ld_rvalid && (q_empty || (head.src != WB_DMEM));
        err_d = err_q || stray;
        err   = err_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

endmodule

// File: tb/tb_wb_ctrl.sv
// Directed self-checking bench for wb_ctrl: inputs change just after the
// rising edge, combinational outputs are checked 1 time unit later.
module tb_wb_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        iss_valid;
    logic        iss_ready;
    logic [4:0]  iss_rd;
    logic [1:0]  iss_src;
    logic [31:0] iss_data;
    logic        ld_rvalid;
    logic [1:0]  wb_sel;
    logic [31:0] wb_alu;
    logic [31:0] wb_pc4;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [4:0]  hz_rs1;
    logic [4:0]  hz_rs2;
    logic        hazard;
    logic        err;
    logic        busy;

    int checks = 0;
    int errors = 0;

    wb_ctrl u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .iss_valid (iss_valid),
        .iss_ready (iss_ready),
        .iss_rd    (iss_rd),
        .iss_src   (iss_src),
        .iss_data  (iss_data),
        .ld_rvalid (ld_rvalid),
        .wb_sel    (wb_sel),
        .wb_alu    (wb_alu),
        .wb_pc4    (wb_pc4),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .hz_rs1    (hz_rs1),
        .hz_rs2    (hz_rs2),
        .hazard    (hazard),
        .err       (err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] rd, input logic [1:0] src, input logic [31:0] data);
        iss_valid = 1'b1;
        iss_rd    = rd;
        iss_src   = src;
        iss_data  = data;
        tick();
        iss_valid = 1'b0;
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        iss_valid = 1'b0;
        iss_rd    = '0;
        iss_src   = '0;
        iss_data  = '0;
        ld_rvalid = 1'b0;
        hz_rs1    = '0;
        hz_rs2    = '0;
        #2;
        chk("rst_ready",  64'(iss_ready), 64'(1));
        chk("rst_we",     64'(rf_we),     64'(0));
        chk("rst_sel",    64'(wb_sel),    64'(1));
        chk("rst_hazard", 64'(hazard),    64'(0));
        chk("rst_busy",   64'(busy),      64'(0));
        chk("rst_waddr",  64'(rf_waddr),  64'(0));
        chk("rst_alu",    64'(wb_alu),    64'(0));
        chk("rst_pc4",    64'(wb_pc4),    64'(0));
        chk("rst_err",    64'(err),       64'(0));
        #10;
        rst_n = 1'b1;
        tick();

        // Single ALU writeback, one cycle after enqueue
        issue(5'd5, 2'b01, 32'h1234);
        chk("alu_we",    64'(rf_we),    64'(1));
        chk("alu_waddr", 64'(rf_waddr), 64'(5));
        chk("alu_sel",   64'(wb_sel),   64'(1));
        chk("alu_data",  64'(wb_alu),   64'(32'h1234));
        tick();
        chk("alu_idle",  64'(busy),     64'(0));

        // Load blocks the younger ALU entry until its response
        issue(5'd7, 2'b00, 32'h0);
        issue(5'd8, 2'b01, 32'hAAAA);
        hz_rs1 = 5'd8;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("ld_wait_we",  64'(rf_we),  64'(0));
            chk("ld_wait_hz",  64'(hazard), 64'(1));
            chk("ld_wait_sel", 64'(wb_sel), 64'(0));
            tick();
        end
        ld_rvalid = 1'b1;
        #1;
        chk("ld_we",    64'(rf_we),    64'(1));
        chk("ld_waddr", 64'(rf_waddr), 64'(7));
        chk("ld_sel",   64'(wb_sel),   64'(0));
        tick();
        ld_rvalid = 1'b0;
        #1;
        chk("ld_next_we",    64'(rf_we),    64'(1));
        chk("ld_next_waddr", 64'(rf_waddr), 64'(8));
        chk("ld_next_data",  64'(wb_alu),   64'(32'hAAAA));
        tick();
        hz_rs1 = 5'd0;
        #1;
        chk("ld_drained", 64'(busy),   64'(0));
        chk("ld_no_hz",   64'(hazard), 64'(0));

        // Fill with loads across the pointer wrap
        for (int k = 1; k <= 4; k++) begin
            issue(5'(k), 2'b00, 32'h0);
        end
        chk("full_ready", 64'(iss_ready), 64'(0));
        iss_valid = 1'b1;
        iss_rd    = 5'd9;
        iss_src   = 2'b01;
        iss_data  = 32'h9;
        #1;
        chk("full_hold", 64'(iss_ready), 64'(0));
        tick();
        iss_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            ld_rvalid = 1'b1;
            #1;
            chk("wrap_we",    64'(rf_we),    64'(1));
            chk("wrap_waddr", 64'(rf_waddr), 64'(k));
            tick();
            ld_rvalid = 1'b0;
            tick();
        end
        chk("wrap_ready", 64'(iss_ready), 64'(1));
        chk("wrap_empty", 64'(busy),      64'(0));

        // x0 and no-writeback entries never write
        issue(5'd0, 2'b01, 32'h5);
        chk("x0_we", 64'(rf_we),  64'(0));
        chk("x0_hz", 64'(hazard), 64'(0));
        issue(5'd3, 2'b11, 32'h0);
        chk("none_we",   64'(rf_we),  64'(0));
        chk("none_sel",  64'(wb_sel), 64'(3));
        chk("none_busy", 64'(busy),   64'(1));
        hz_rs2 = 5'd3;
        #1;
        chk("none_hz", 64'(hazard), 64'(1));
        tick();
        hz_rs2 = 5'd0;
        #1;
        chk("none_done", 64'(busy), 64'(0));

        // Stray load response sets sticky err; queue keeps working
        ld_rvalid = 1'b1;
        #1;
        chk("stray_pre", 64'(err), 64'(0));
        tick();
        ld_rvalid = 1'b0;
        #1;
        chk("stray_err",  64'(err),  64'(1));
        chk("stray_busy", 64'(busy), 64'(0));
        issue(5'd6, 2'b10, 32'h44);
        chk("pc4_we",    64'(rf_we),    64'(1));
        chk("pc4_waddr", 64'(rf_waddr), 64'(6));
        chk("pc4_sel",   64'(wb_sel),   64'(2));
        chk("pc4_data",  64'(wb_pc4),   64'(32'h44));
        chk("err_stick", 64'(err),      64'(1));
        tick();
        issue(5'd10, 2'b00, 32'h0);
        chk("pend_busy", 64'(busy), 64'(1));
        rst_n = 1'b0;
        #1;
        chk("arst_err",   64'(err),       64'(0));
        chk("arst_busy",  64'(busy),      64'(0));
        chk("arst_ready", 64'(iss_ready), 64'(1));
        rst_n = 1'b1;
        ld_rvalid = 1'b1;
        tick();
        ld_rvalid = 1'b0;
        #1;
        chk("late_err", 64'(err), 64'(1));

        // Back-to-back stream, one retire per cycle, alternating sources
        for (int i = 0; i < 10; i++) begin
            iss_valid = 1'b1;
            iss_rd    = 5'(i + 1);
            iss_src   = (i % 2 == 0) ? 2'b01 : 2'b10;
            iss_data  = 32'h100 + 32'(i);
            #1;
            if (i == 0) begin
                chk("strm_first_we", 64'(rf_we), 64'(0));
            end else begin
                chk("strm_we",    64'(rf_we),    64'(1));
                chk("strm_waddr", 64'(rf_waddr), 64'(i));
                chk("strm_sel",   64'(wb_sel),   64'(((i - 1) % 2 == 0) ? 1 : 2));
                chk("strm_alu",   64'(wb_alu),   64'(32'h100 + 32'(i - 1)));
                chk("strm_pc4",   64'(wb_pc4),   64'(32'h100 + 32'(i - 1)));
            end
            tick();
        end
        iss_valid = 1'b0;
        #1;
        chk("strm_last_we",    64'(rf_we),    64'(1));
        chk("strm_last_waddr", 64'(rf_waddr), 64'(10));
        chk("strm_last_sel",   64'(wb_sel),   64'(2));
        chk("strm_last_data",  64'(wb_pc4),   64'(32'h109));
        tick();
        chk("strm_done", 64'(busy), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
